// File: rtl/frame_pkg.sv
// Shared types and constants for the frame loader.
package frame_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StPending
  } state_e;

  localparam int unsigned CELL_R_BIT = 2;
  localparam int unsigned CELL_G_BIT = 1;
  localparam int unsigned CELL_B_BIT = 0;

  localparam logic [7:0] CELL_RSVD_MASK    = 8'hF8;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/frame_bank.sv
// One RGB cell plane set with a single write port and full-array read.
module frame_bank
  import frame_pkg::*;
#(
  parameter int unsigned FRAME_WIDTH  = 10,
  parameter int unsigned FRAME_HEIGHT = 20,
  parameter int unsigned XW           = 4,
  parameter int unsigned YW           = 5
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    we,
  input  logic [XW-1:0]                           x,
  input  logic [YW-1:0]                           y,
  input  logic [2:0]                              rgb,
  output logic [FRAME_HEIGHT-1:0][FRAME_WIDTH-1:0] r,
  output logic [FRAME_HEIGHT-1:0][FRAME_WIDTH-1:0] g,
  output logic [FRAME_HEIGHT-1:0][FRAME_WIDTH-1:0] b
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r <= '0;
      g <= '0;
      b <= '0;
    end else if (we) begin
      r[y][x] <= rgb[CELL_R_BIT];
      g[y][x] <= rgb[CELL_G_BIT];
      b[y][x] <= rgb[CELL_B_BIT];
    end
  end

endmodule

// File: rtl/frame_loader.sv
// Assembles SYNC-framed cell bytes into a back bank and swaps banks on vblank.
module frame_loader
  import frame_pkg::*;
#(
  parameter int unsigned FRAME_WIDTH    = 10,
  parameter int unsigned FRAME_HEIGHT   = 20,
  parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned COUNT_WIDTH    = 16,
  parameter int unsigned ERR_WIDTH      = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   swap_strobe,
  output logic                   frame_R [FRAME_HEIGHT-1:0][FRAME_WIDTH-1:0],
  output logic                   frame_G [FRAME_HEIGHT-1:0][FRAME_WIDTH-1:0],
  output logic                   frame_B [FRAME_HEIGHT-1:0][FRAME_WIDTH-1:0],
  output logic                   frame_valid,
  output logic                   loading,
  output logic [COUNT_WIDTH-1:0] frames_loaded,
  output logic [ERR_WIDTH-1:0]   err_count
);

  localparam int unsigned XW = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
  localparam int unsigned YW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [XW-1:0] XLast   = XW'(FRAME_WIDTH - 1);
  localparam logic [YW-1:0] YLast   = YW'(FRAME_HEIGHT - 1);
  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT_CYCLES - 1);

  state_e               state_q, state_d;
  logic [XW-1:0]        x_q, x_d;
  logic [YW-1:0]        y_q, y_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic [ERR_WIDTH-1:0] err_q, err_d;
  logic [COUNT_WIDTH-1:0] frames_q, frames_d;
  logic                 front_sel_q, front_sel_d;
  logic                 valid_q, valid_d;

  logic accept, we, err_inc;

  logic [FRAME_HEIGHT-1:0][FRAME_WIDTH-1:0] b0_r, b0_g, b0_b;
  logic [FRAME_HEIGHT-1:0][FRAME_WIDTH-1:0] b1_r, b1_g, b1_b;

  assign in_ready      = (state_q != StPending);
  assign accept        = in_valid && in_ready;
  assign loading       = (state_q == StLoad);
  assign frame_valid   = valid_q;
  assign frames_loaded = frames_q;
  assign err_count     = err_q;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    tmo_d       = tmo_q;
    err_d       = err_q;
    frames_d    = frames_q;
    front_sel_d = front_sel_q;
    valid_d     = valid_q;
    we          = 1'b0;
    err_inc     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept && (in_data == SYNC_BYTE)) begin
          state_d = StLoad;
          x_d     = '0;
          y_d     = '0;
          tmo_d   = '0;
        end
      end
      StLoad: begin
        if (accept) begin
          tmo_d = '0;
          if ((in_data & CELL_RSVD_MASK) == 8'h00) begin
            we = 1'b1;
            if (y_q == YLast) begin
              y_d = '0;
              if (x_q == XLast) begin
                state_d = StPending;
              end else begin
                x_d = x_q + 1'b1;
              end
            end else begin
              y_d = y_q + 1'b1;
            end
          end else begin
            // A sync byte mid-frame restarts the frame; anything else aborts.
            err_inc = 1'b1;
            x_d     = '0;
            y_d     = '0;
            if (in_data != SYNC_BYTE) begin
              state_d = StIdle;
            end
          end
        end else if (tmo_q == TmoLast) begin
          err_inc = 1'b1;
          tmo_d   = '0;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StPending: begin
        if (swap_strobe) begin
          front_sel_d = ~front_sel_q;
          valid_d     = 1'b1;
          frames_d    = frames_q + 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (err_inc && (err_q != {ERR_WIDTH{1'b1}})) begin
      err_d = err_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      x_q         <= '0;
      y_q         <= '0;
      tmo_q       <= '0;
      err_q       <= '0;
      frames_q    <= '0;
      front_sel_q <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      frames_q    <= frames_d;
      front_sel_q <= front_sel_d;
      valid_q     <= valid_d;
    end
  end

  // Writes always target the bank that is not on display.
  frame_bank #(
    .FRAME_WIDTH (FRAME_WIDTH),
    .FRAME_HEIGHT(FRAME_HEIGHT),
    .XW          (XW),
    .YW          (YW)
  ) u_bank0 (
    .clk  (clk),
    .rst_n(reset),
    .we   (we && front_sel_q),
    .x    (x_q),
    .y    (y_q),
    .rgb  (in_data[2:0]),
    .r    (b0_r),
    .g    (b0_g),
    .b    (b0_b)
  );

  frame_bank #(
    .FRAME_WIDTH (FRAME_WIDTH),
    .FRAME_HEIGHT(FRAME_HEIGHT),
    .XW          (XW),
    .YW          (YW)
  ) u_bank1 (
    .clk  (clk),
    .rst_n(reset),
    .we   (we && !front_sel_q),
    .x    (x_q),
    .y    (y_q),
    .rgb  (in_data[2:0]),
    .r    (b1_r),
    .g    (b1_g),
    .b    (b1_b)
  );

  always_comb begin
    for (int unsigned yy = 0; yy < FRAME_HEIGHT; yy++) begin
      for (int unsigned xx = 0; xx < FRAME_WIDTH; xx++) begin
        frame_R[yy][xx] = front_sel_q ? b1_r[yy][xx] : b0_r[yy][xx];
        frame_G[yy][xx] = front_sel_q ? b1_g[yy][xx] : b0_g[yy][xx];
        frame_B[yy][xx] = front_sel_q ? b1_b[yy][xx] : b0_b[yy][xx];
      end
    end
  end

endmodule

// File: doc/frame_loader.md
Name: frame_loader

Overview:
Receives game frames from the MCU byte stream (SPI receiver output, valid/ready) and assembles them into a double-buffered cell array. Drives the frame_R/G/B cell arrays consumed by the panel renderer, which is directly downstream. Bank swaps occur only on a vblank strobe, so the display never tears. Exports frame and error counters for telemetry.

Parameters:
FRAME_WIDTH, 10, columns (x cells)
FRAME_HEIGHT, 20, rows (y cells)
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CYCLES, 1000000, max clk cycles between bytes inside a frame before abort
COUNT_WIDTH, 16, frames_loaded width
ERR_WIDTH, 8, err_count width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
in_data  in  8  byte from SPI receiver
in_valid  in  1  in_data valid
in_ready  out  1  loader can accept a byte
swap_strobe  in  1  1-cycle pulse at vblank start, from VGA timing
frame_R  out  [FRAME_HEIGHT-1:0] x [FRAME_WIDTH-1:0] unpacked  front-bank red plane
frame_G  out  same  front-bank green plane
frame_B  out  same  front-bank blue plane
frame_valid  out  1  at least one frame has been displayed since reset
loading  out  1  state is LOAD
frames_loaded  out  COUNT_WIDTH  count of swapped-in frames; wraps
err_count  out  ERR_WIDTH  protocol errors plus timeouts; saturates

Behaviour:
- Reset (async assert, sync release): state=IDLE, both banks all-zero, front_sel=0, frame_valid=0, frames_loaded=0, err_count=0, cell index=0, timeout counter=0, in_ready=1.
- Accept: a byte is accepted only when in_valid && in_ready in the same cycle. in_ready=1 in IDLE and LOAD, 0 in PENDING.
- Wire format: SYNC_BYTE, then FRAME_WIDTH*FRAME_HEIGHT cell bytes. Cells are column-major: x outer, y inner. Cell byte bit2=R, bit1=G, bit0=B; bits[7:3] must be 0.
- IDLE:
  - Accepted SYNC_BYTE -> LOAD; x=0, y=0, timeout counter=0.
  - Any other accepted byte is dropped silently, with no error.
- LOAD:
  - Accepted valid cell byte: write back bank[x][y] in the same cycle, then advance y. When y=FRAME_HEIGHT-1, y wraps to 0 and x increments. Timeout counter clears.
  - Last cell (x=W-1, y=H-1) accepted -> PENDING.
  - Accepted byte with bits[7:3]!=0:
    - If it equals SYNC_BYTE: err_count+1, restart at x=0, y=0, stay in LOAD (resync).
    - Otherwise: err_count+1 -> IDLE.
  - No accepted byte for TIMEOUT_CYCLES consecutive cycles: err_count+1 -> IDLE. The partial back bank is discarded and the front bank is untouched.
- PENDING:
  - On swap_strobe: toggle front_sel, set frame_valid=1, frames_loaded+1 (wraps), -> IDLE.
  - A strobe in the same cycle that LOAD accepts the last cell is ignored; the swap happens on the next strobe.
- Outputs: frame_R/G/B = bank[front_sel], registered through the bank flops. They change only on the cycle after a swap. A write to the back bank never alters the outputs.
- err_count holds at 2^ERR_WIDTH-1.
- Reset mid-frame: everything returns to reset values immediately, including the displayed banks, which go to zero.
- swap_strobe in IDLE or LOAD has no effect.

Decomposition:
- Package frame_pkg holds:
  - state enum {IDLE, LOAD, PENDING}
  - cell bit-position constants CELL_R_BIT=2, CELL_G_BIT=1, CELL_B_BIT=0
  - CELL_RSVD_MASK=8'hF8
  - default SYNC_BYTE
- One sub-module, frame_bank: one RGB cell array with a single write port (we, x, y, rgb), async active-low clear, and full-array read outputs.
- frame_loader instantiates two frame_bank instances and muxes them by front_sel.

Test Plan:
- Reset, then send A5 followed by 200 bytes with cell(x,y)=(x+y)%8 -> in_ready low after the last byte; outputs still zero; after one swap_strobe, frame_R[3][2]=1, frame_G[3][2]=0, frame_B[3][2]=1 (value 5); frames_loaded=1; frame_valid=1.
- Send frame A, swap, send frame B with no strobe -> outputs still equal A. Strobe -> outputs equal B; frames_loaded=2.
- Send A5 plus 50 cells, then 0x3C -> err_count=1, state IDLE. Front bank unchanged. A following full frame loads correctly.
- Send A5 plus 50 cells, then A5 plus 200 cells -> err_count=1; the frame completes. Strobe -> the second frame is shown.
- Send A5 plus 10 cells, then idle for TIMEOUT_CYCLES (set to 100 in the bench) -> err_count=1 at cycle 100, loading=0. Hold in_valid=1 during PENDING -> no byte is consumed.
- Assert reset mid-LOAD and hold in_valid with random data -> all outputs zero immediately; after release, only SYNC_BYTE starts a load. Force 300 errors -> err_count=255.
